pio_input_shift_register: RTL and testbench

//  Input Shift Register (ISR) stage of a PIO state machine, directly downstream of the pin block.

---
 rtl/pio_input_shift_register_if.sv | 9 +
 rtl/pio_input_shift_register.sv | 108 ++++++++++
 tb/tb_pio_input_shift_register.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_input_shift_register_if.sv
// RX FIFO handshake between the ISR stage (master) and the FIFO (slave).
interface pio_input_shift_register_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/pio_input_shift_register.sv
// PIO input shift register: shifts pin bits into the ISR and hands completed
// words to the RX FIFO via explicit PUSH or autopush, with a one-word output buffer.
module pio_input_shift_register #(
  parameter int WIDTH = 32,
  localparam int CW   = $clog2(WIDTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cfg_shiftRight,
  input  logic                 cfg_autoPush,
  input  logic [CW-1:0]        cfg_pushThresh,
  input  logic [WIDTH-1:0]     pin_data,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_bitCount,
  input  logic                 push_req,
  input  logic                 push_block,
  input  logic                 push_ifFull,
  input  logic                 clear,
  pio_input_shift_register_if.master rx,
  output logic [WIDTH-1:0]     isr_value,
  output logic [CW-1:0]        shift_count,
  output logic                 stall
);
  typedef enum logic {IDLE, FULL} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0]    WMAX = CW'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] isr, rxData, shifted, mask;
  logic [CW-1:0]    cnt, n, thr, satCount;
  logic [CW:0]      sum;
  logic             rxValid, outFree, pushEff, autoHit;

  // Zero encodes the full width for both bit count and threshold.
  assign n   = (in_bitCount == '0) ? WMAX : in_bitCount;
  assign thr = (cfg_pushThresh == '0) ? WMAX : cfg_pushThresh;

  assign sum      = {1'b0, cnt} + {1'b0, n};
  assign satCount = (sum > {1'b0, WMAX}) ? WMAX : sum[CW-1:0];

  always_comb begin
    mask    = (ONE << n) - ONE;
    shifted = pin_data;
    if (n != WMAX) begin
      if (cfg_shiftRight) shifted = (isr >> n) | (pin_data << (WMAX - n));
      else                shifted = (isr << n) | (pin_data & mask);
    end
  end

  // The buffer is free if empty or if its word leaves on this same edge.
  assign outFree = (state == IDLE) || rx.rx_ready;
  assign pushEff = !(push_ifFull && (cnt < thr));
  assign autoHit = cfg_autoPush && (satCount >= thr);

  assign stall = (in_valid && push_req) ||
                 ((state == FULL) && !rx.rx_ready &&
                  ((in_valid && autoHit) || (push_req && push_block && pushEff)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      isr     <= '0;
      cnt     <= '0;
      rxData  <= '0;
      rxValid <= 1'b0;
    end else begin
      if (rxValid && rx.rx_ready) begin
        state   <= IDLE;
        rxValid <= 1'b0;
      end
      if (clear) begin
        isr <= '0;
        cnt <= '0;
      end else if (push_req) begin
        if (pushEff && outFree) begin
          rxData  <= isr;
          rxValid <= 1'b1;
          state   <= FULL;
          isr     <= '0;
          cnt     <= '0;
        end else if (pushEff && !push_block) begin
          // Non-blocking push into an occupied buffer drops the word.
          isr <= '0;
          cnt <= '0;
        end
      end else if (in_valid) begin
        if (autoHit) begin
          if (outFree) begin
            rxData  <= shifted;
            rxValid <= 1'b1;
            state   <= FULL;
            isr     <= '0;
            cnt     <= '0;
          end
        end else begin
          isr <= shifted;
          cnt <= satCount;
        end
      end
    end
  end

  assign rx.rx_data  = rxData;
  assign rx.rx_valid = rxValid;
  assign isr_value   = isr;
  assign shift_count = cnt;
endmodule

// File: tb/tb_pio_input_shift_register.sv
// Bench for the PIO ISR stage: table-driven shift vectors plus a word scoreboard.
module tb_pio_input_shift_register;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        cfg_shiftRight, cfg_autoPush;
  logic [5:0]  cfg_pushThresh, in_bitCount;
  logic [31:0] pin_data;
  logic        in_valid, push_req, push_block, push_ifFull, clear;
  logic [31:0] isr_value;
  logic [5:0]  shift_count;
  logic        stall;

  pio_input_shift_register_if #(.WIDTH(32)) rx ();

  pio_input_shift_register dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_shiftRight(cfg_shiftRight), .cfg_autoPush(cfg_autoPush),
    .cfg_pushThresh(cfg_pushThresh), .pin_data(pin_data),
    .in_valid(in_valid), .in_bitCount(in_bitCount),
    .push_req(push_req), .push_block(push_block), .push_ifFull(push_ifFull),
    .clear(clear), .rx(rx.master),
    .isr_value(isr_value), .shift_count(shift_count), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic        right;
    logic [5:0]  n;
    logic [31:0] data;
    logic [31:0] expIsr;
    logic [5:0]  expCnt;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int gotIdx = 0;
  int expTotal = 0;

  // Record every word the FIFO accepts, in handshake order.
  always @(negedge clock)
    if (reset_n && rx.rx_valid && rx.rx_ready) got_q.push_back(rx.rx_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expWord(input logic [31:0] w);
    exp_q.push_back(w);
    expTotal++;
  endtask

  task automatic scoreCheck();
    while (gotIdx < got_q.size()) begin
      if (exp_q.size() == 0) chk("sb_unexpected", got_q[gotIdx], 32'hxxxxxxxx);
      else chk("sb_word", got_q[gotIdx], exp_q.pop_front());
      gotIdx++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; push_req = 0; clear = 0;
  endtask

  task automatic drvIn(input logic right, input logic [5:0] nb, input logic [31:0] d);
    cfg_shiftRight = right; in_bitCount = nb; pin_data = d; in_valid = 1;
  endtask

  task automatic doClear();
    clear = 1; tick(); clear = 0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 0, 6'd4,  32'h1, 32'h00000001, 6'd4};
    vecs[1]  = '{0, 0, 6'd4,  32'h2, 32'h00000012, 6'd8};
    vecs[2]  = '{0, 0, 6'd4,  32'h3, 32'h00000123, 6'd12};
    vecs[3]  = '{0, 0, 6'd4,  32'h4, 32'h00001234, 6'd16};
    vecs[4]  = '{0, 0, 6'd4,  32'h5, 32'h00012345, 6'd20};
    vecs[5]  = '{0, 0, 6'd4,  32'h6, 32'h00123456, 6'd24};
    vecs[6]  = '{0, 0, 6'd4,  32'h7, 32'h01234567, 6'd28};
    vecs[7]  = '{0, 0, 6'd4,  32'h8, 32'h12345678, 6'd32};
    vecs[8]  = '{0, 0, 6'd4,  32'h9, 32'h23456789, 6'd32};
    vecs[9]  = '{1, 1, 6'd8,  32'hAB, 32'hAB000000, 6'd8};
    vecs[10] = '{0, 1, 6'd8,  32'hCD, 32'hCDAB0000, 6'd16};
    vecs[11] = '{1, 0, 6'd0,  32'hDEADBEEF, 32'hDEADBEEF, 6'd32};
    vecs[12] = '{0, 1, 6'd0,  32'h12345678, 32'h12345678, 6'd32};
    vecs[13] = '{1, 0, 6'd31, 32'h7FFFFFFF, 32'h7FFFFFFF, 6'd31};
    vecs[14] = '{0, 0, 6'd1,  32'h1, 32'hFFFFFFFF, 6'd32};

    reset_n = 0; cfg_shiftRight = 0; cfg_autoPush = 0; cfg_pushThresh = 6'd8;
    pin_data = 0; in_bitCount = 0; push_block = 0; push_ifFull = 0;
    rx.rx_ready = 0;
    idle();
    #2;
    chk("rst_valid", {31'b0, rx.rx_valid}, 32'd0);
    chk("rst_isr", isr_value, 32'd0);
    chk("rst_cnt", {26'b0, shift_count}, 32'd0);
    chk("rst_data", rx.rx_data, 32'd0);
    repeat (2) tick();
    reset_n = 1;
    tick();

    // Table-driven shift vectors, autopush disabled.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].clr) doClear();
      drvIn(vecs[i].right, vecs[i].n, vecs[i].data);
      tick();
      idle();
      chk($sformatf("vec%0d_isr", i), isr_value, vecs[i].expIsr);
      chk($sformatf("vec%0d_cnt", i), {26'b0, shift_count}, {26'b0, vecs[i].expCnt});
    end
    chk("vec_no_valid", {31'b0, rx.rx_valid}, 32'd0);

    // Autopush at threshold 8 with a ready FIFO.
    doClear();
    cfg_autoPush = 1; rx.rx_ready = 1;
    drvIn(0, 6'd4, 32'hA); tick();
    drvIn(0, 6'd4, 32'h5); expWord(32'hA5); tick(); idle();
    chk("ap_valid", {31'b0, rx.rx_valid}, 32'd1);
    chk("ap_data", rx.rx_data, 32'hA5);
    chk("ap_isr", isr_value, 32'd0);
    chk("ap_cnt", {26'b0, shift_count}, 32'd0);
    tick();
    chk("ap_valid_1cyc", {31'b0, rx.rx_valid}, 32'd0);
    scoreCheck();

    // Backpressure: second threshold-reaching IN stalls until the FIFO is ready.
    rx.rx_ready = 0;
    drvIn(0, 6'd4, 32'h1); tick();
    drvIn(0, 6'd4, 32'h2); expWord(32'h12); tick();
    drvIn(0, 6'd4, 32'h3); tick();
    drvIn(0, 6'd4, 32'h4); #1;
    chk("bp_stall", {31'b0, stall}, 32'd1);
    tick(); tick();
    chk("bp_isr_hold", isr_value, 32'h3);
    chk("bp_cnt_hold", {26'b0, shift_count}, 32'd4);
    chk("bp_data_hold", rx.rx_data, 32'h12);
    rx.rx_ready = 1; #1;
    chk("bp_unstall", {31'b0, stall}, 32'd0);
    expWord(32'h34); tick(); idle();
    chk("bp_data2", rx.rx_data, 32'h34);
    chk("bp_valid2", {31'b0, rx.rx_valid}, 32'd1);
    chk("bp_isr_clr", isr_value, 32'd0);
    tick();
    chk("bp_drained", {31'b0, rx.rx_valid}, 32'd0);
    scoreCheck();

    // PUSH variants, autopush off.
    cfg_autoPush = 0; doClear();
    drvIn(0, 6'd4, 32'h4); tick(); idle();
    push_req = 1; push_ifFull = 1; #1;
    chk("pf_nostall", {31'b0, stall}, 32'd0);
    tick(); idle();
    chk("pf_noop_valid", {31'b0, rx.rx_valid}, 32'd0);
    chk("pf_noop_isr", isr_value, 32'h4);
    rx.rx_ready = 0; push_ifFull = 0; push_block = 0; push_req = 1;
    expWord(32'h4); tick(); idle();
    chk("p_valid", {31'b0, rx.rx_valid}, 32'd1);
    chk("p_data", rx.rx_data, 32'h4);
    chk("p_isr", isr_value, 32'd0);
    drvIn(0, 6'd4, 32'h7); tick(); idle();
    push_req = 1; push_block = 0; #1;
    chk("pnb_nostall", {31'b0, stall}, 32'd0);
    tick(); idle();
    chk("pnb_isr", isr_value, 32'd0);
    chk("pnb_cnt", {26'b0, shift_count}, 32'd0);
    chk("pnb_data", rx.rx_data, 32'h4);
    drvIn(0, 6'd4, 32'h9); tick(); idle();
    push_req = 1; push_block = 1; #1;
    chk("pb_stall", {31'b0, stall}, 32'd1);
    tick(); tick();
    chk("pb_isr_hold", isr_value, 32'h9);
    chk("pb_data_hold", rx.rx_data, 32'h4);
    rx.rx_ready = 1; #1;
    chk("pb_unstall", {31'b0, stall}, 32'd0);
    expWord(32'h9); tick(); idle();
    chk("pb_data2", rx.rx_data, 32'h9);
    chk("pb_valid2", {31'b0, rx.rx_valid}, 32'd1);
    tick();
    chk("pb_drained", {31'b0, rx.rx_valid}, 32'd0);
    push_block = 0;
    scoreCheck();

    // IN and PUSH together: the IN is stalled.
    drvIn(0, 6'd4, 32'h1); push_req = 1; push_ifFull = 1; #1;
    chk("inpush_stall", {31'b0, stall}, 32'd1);
    tick(); idle(); push_ifFull = 0;
    chk("inpush_isr", isr_value, 32'd0);

    // clear with concurrent IN while a word is pending.
    rx.rx_ready = 0;
    drvIn(0, 6'd4, 32'h5); tick(); idle();
    push_req = 1; expWord(32'h5); tick(); idle();
    drvIn(0, 6'd4, 32'h6); tick(); idle();
    chk("clr_pre_isr", isr_value, 32'h6);
    clear = 1; drvIn(0, 6'd4, 32'h7); tick(); idle();
    chk("clr_isr", isr_value, 32'd0);
    chk("clr_cnt", {26'b0, shift_count}, 32'd0);
    tick(); tick();
    chk("clr_valid_held", {31'b0, rx.rx_valid}, 32'd1);
    chk("clr_data_held", rx.rx_data, 32'h5);
    rx.rx_ready = 1; tick();
    chk("clr_drained", {31'b0, rx.rx_valid}, 32'd0);
    scoreCheck();

    // Async reset in the middle of FULL.
    rx.rx_ready = 0;
    drvIn(0, 6'd4, 32'h3); tick(); idle();
    push_req = 1; tick(); idle();
    drvIn(0, 6'd4, 32'h8); tick(); idle();
    chk("ar_full", {31'b0, rx.rx_valid}, 32'd1);
    #2 reset_n = 0; #1;
    chk("ar_valid", {31'b0, rx.rx_valid}, 32'd0);
    chk("ar_isr", isr_value, 32'd0);
    chk("ar_cnt", {26'b0, shift_count}, 32'd0);
    tick();
    reset_n = 1;
    tick();

    scoreCheck();
    chk("sb_total", got_q.size(), expTotal);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
